switch_debounce: RTL and testbench

Synchronizes and debounces a bank of raw slide switches/push buttons and produces clean levels plus one-cycle edge pulses. Sits directly upstream of the LED/logic stages that consume switch inputs, replacing direct pin-to-logic wiring. Each bit is filtered independently: an output level changes only after the synchronized input has held the new value for STABLE_CYCLES consecutive clocks.

---
 rtl/switch_debounce.sv | 104 ++++++++++
 tb/tb_switch_debounce.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/switch_debounce.sv
// -----------------------------------------------------------------------------
// switch_debounce
//
// Synchronizes and debounces a bank of raw switch / push-button pins. Each
// channel is filtered on its own: the debounced level only changes after the
// synchronized input has disagreed with it for STABLE_CYCLES consecutive
// clocks. Any single cycle of agreement restarts the count from zero.
//
// Parameters
//   WIDTH          number of independent channels (>= 1)
//   STABLE_CYCLES  consecutive disagreeing cycles needed to accept a new level
//                  (2 .. 2^24)
//
// Ports
//   clk        system clock, all logic on the rising edge
//   reset_n    synchronous active-low reset
//   switch_in  raw asynchronous switch pins
//   switch_db  debounced level (registered)
//   rise       one-cycle pulse when a switch_db bit goes 0->1
//   fall       one-cycle pulse when a switch_db bit goes 1->0
//   toggle     level that inverts on every rise of its bit
// -----------------------------------------------------------------------------
module switch_debounce #(
    parameter int WIDTH         = 4,
    parameter int STABLE_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] switch_in,
    output logic [WIDTH-1:0] switch_db,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] toggle
);

    // The counter only ever has to reach STABLE_CYCLES-1, which always fits
    // in $clog2(STABLE_CYCLES) bits for the legal parameter range.
    localparam int              CNT_W   = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_chan
            logic             sync1_reg;
            logic             sync2_reg;
            logic [CNT_W-1:0] cnt_reg,    cnt_next;
            logic             db_reg,     db_next;
            logic             rise_reg,   rise_next;
            logic             fall_reg,   fall_next;
            logic             toggle_reg, toggle_next;

            // Filter decision for this channel.
            always_comb begin
                cnt_next    = cnt_reg;
                db_next     = db_reg;
                rise_next   = 1'b0;
                fall_next   = 1'b0;
                toggle_next = toggle_reg;

                if (sync2_reg == db_reg) begin
                    // Input agrees with the accepted level: no credit kept.
                    cnt_next = '0;
                end else if (cnt_reg == CNT_MAX) begin
                    // Final disagreeing cycle: accept the new level and emit
                    // the matching edge pulse.
                    db_next     = sync2_reg;
                    cnt_next    = '0;
                    rise_next   = sync2_reg;
                    fall_next   = ~sync2_reg;
                    toggle_next = toggle_reg ^ sync2_reg;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    sync1_reg  <= 1'b0;
                    sync2_reg  <= 1'b0;
                    cnt_reg    <= '0;
                    db_reg     <= 1'b0;
                    rise_reg   <= 1'b0;
                    fall_reg   <= 1'b0;
                    toggle_reg <= 1'b0;
                end else begin
                    // Plain two-flop synchronizer, nothing between the flops.
                    sync1_reg  <= switch_in[gi];
                    sync2_reg  <= sync1_reg;
                    cnt_reg    <= cnt_next;
                    db_reg     <= db_next;
                    rise_reg   <= rise_next;
                    fall_reg   <= fall_next;
                    toggle_reg <= toggle_next;
                end
            end

            assign switch_db[gi] = db_reg;
            assign rise[gi]      = rise_reg;
            assign fall[gi]      = fall_reg;
            assign toggle[gi]    = toggle_reg;
        end
    endgenerate

endmodule

// File: tb/tb_switch_debounce.sv
// -----------------------------------------------------------------------------
// tb_switch_debounce
//
// Directed bench for switch_debounce with WIDTH=2, STABLE_CYCLES=4. Inputs are
// changed 1 ns after a rising edge and outputs are sampled at the same point,
// so every sample reflects the edge just taken. With STABLE_CYCLES=4 a clean
// change applied between edges 0 and 1 shows at the outputs after edge 6.
// -----------------------------------------------------------------------------
module tb_switch_debounce;

    localparam int W = 2;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] switch_in;
    logic [W-1:0] switch_db;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [W-1:0] toggle;

    int n_cmp = 0;
    int n_bad = 0;

    switch_debounce #(
        .WIDTH         (W),
        .STABLE_CYCLES (S)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .switch_in (switch_in),
        .switch_db (switch_db),
        .rise      (rise),
        .fall      (fall),
        .toggle    (toggle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Take one rising edge and land 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Input change has just been applied (between edges). Expect five edges
    // with the old level and no pulses, the flip on the sixth, and the pulses
    // gone on the seventh.
    task automatic expect_flip(input string tag,
                               input logic [W-1:0] old_db,
                               input logic [W-1:0] new_db,
                               input logic [W-1:0] exp_rise,
                               input logic [W-1:0] exp_fall,
                               input logic [W-1:0] exp_tog);
        for (int i = 1; i <= S + 1; i++) begin
            step();
            chk({tag, "_hold_db"}, 32'(switch_db), 32'(old_db));
            chk({tag, "_hold_pulse"}, 32'({rise, fall}), 32'd0);
        end
        step();
        chk({tag, "_db"}, 32'(switch_db), 32'(new_db));
        chk({tag, "_rise"}, 32'(rise), 32'(exp_rise));
        chk({tag, "_fall"}, 32'(fall), 32'(exp_fall));
        chk({tag, "_toggle"}, 32'(toggle), 32'(exp_tog));
        step();
        chk({tag, "_after_db"}, 32'(switch_db), 32'(new_db));
        chk({tag, "_after_pulse"}, 32'({rise, fall}), 32'd0);
        $display("txn %s: db=%b rise=%b fall=%b toggle=%b", tag, switch_db, rise, fall, toggle);
    endtask

    initial begin
        // ---- Reset with both switches held high -----------------------------
        reset_n   = 1'b0;
        switch_in = 2'b11;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("in_reset", 32'({switch_db, rise, fall, toggle}), 32'd0);
        end
        reset_n = 1'b1;
        expect_flip("reset_release", 2'b00, 2'b11, 2'b11, 2'b00, 2'b11);

        // ---- 3-cycle glitch low on bit 1 must be rejected -------------------
        switch_in = 2'b01;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("glitch_db", 32'(switch_db), 32'b11);
            chk("glitch_fall", 32'(fall), 32'd0);
        end
        switch_in = 2'b11;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("glitch_db", 32'(switch_db), 32'b11);
            chk("glitch_fall", 32'(fall), 32'd0);
        end
        $display("txn glitch: db=%b fall=%b", switch_db, fall);

        // ---- Release then press bit 0: fall then rise, toggle 1,1,0 ---------
        switch_in = 2'b10;
        expect_flip("release0", 2'b11, 2'b10, 2'b00, 2'b01, 2'b11);
        switch_in = 2'b11;
        expect_flip("press0", 2'b10, 2'b11, 2'b01, 2'b00, 2'b10);

        // ---- Bounce on bit 0 then hold high ---------------------------------
        switch_in = 2'b10;
        expect_flip("release0b", 2'b11, 2'b10, 2'b00, 2'b01, 2'b10);
        for (int i = 0; i < 4; i++) begin
            switch_in = (i % 2 == 0) ? 2'b11 : 2'b10;
            step();
            chk("bounce_db", 32'(switch_db), 32'b10);
            chk("bounce_pulse", 32'({rise, fall}), 32'd0);
        end
        // Stable 1 is first captured at the next edge; flip follows S+1 later.
        switch_in = 2'b11;
        expect_flip("bounce0", 2'b10, 2'b11, 2'b01, 2'b00, 2'b11);

        // ---- Reset in the middle of a count ---------------------------------
        switch_in = 2'b10;
        expect_flip("release0c", 2'b11, 2'b10, 2'b00, 2'b01, 2'b11);
        switch_in = 2'b11;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("midcount_db", 32'(switch_db), 32'b10);
        end
        reset_n = 1'b0;
        step();
        chk("midcount_reset", 32'({switch_db, rise, fall, toggle}), 32'd0);
        reset_n = 1'b1;
        expect_flip("midcount_release", 2'b00, 2'b11, 2'b11, 2'b00, 2'b11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
